dual_port_ram_fill: RTL and testbench

Parametrised successor to the single-port system RAM. Port A is the CPU read/write port with asynchronous read. Port B is a registered read-only port for video/tile fetch. A built-in fill engine writes a constant value across an address range, one word per cycle, to clear the framebuffer or tile area without CPU loops.

---
 rtl/dual_port_ram_fill.sv | 127 ++++++++++++
 tb/tb_dual_port_ram_fill.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_ram_fill.sv
// Dual-port RAM: async-read CPU port A, registered read port B,
// and a fill engine that writes a constant over an address range.
//
// Ports:
//   clk, reset (async, active-low)
//   aWriteEnabled/aAddress/aDataIn -> write, aDataOut (comb), aReady
//   bAddress -> bDataOut (1-cycle registered)
//   fillStart/fillBase/fillCount/fillValue -> fillBusy, fillDone
module dual_port_ram_fill #(
  parameter int AddrBits = 16,
  parameter int DataBits = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                aWriteEnabled,
  input  logic [AddrBits-1:0] aAddress,
  input  logic [DataBits-1:0] aDataIn,
  output logic [DataBits-1:0] aDataOut,
  output logic                aReady,
  input  logic [AddrBits-1:0] bAddress,
  output logic [DataBits-1:0] bDataOut,
  input  logic                fillStart,
  input  logic [AddrBits-1:0] fillBase,
  input  logic [AddrBits:0]   fillCount,
  input  logic [DataBits-1:0] fillValue,
  output logic                fillBusy,
  output logic                fillDone
);

  localparam int Depth = 1 << AddrBits;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } state_t;

  logic [DataBits-1:0] mem [Depth];

  state_t              state, state_nx;
  logic [AddrBits-1:0] ptr, ptr_nx;
  logic [AddrBits:0]   rem, rem_nx;
  logic [DataBits-1:0] val, val_nx;

  logic                fill_we;
  logic                wr_en;
  logic [AddrBits-1:0] wr_addr;
  logic [DataBits-1:0] wr_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ptr      <= '0;
      rem      <= '0;
      val      <= '0;
      fillBusy <= 1'b0;
      fillDone <= 1'b0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      rem      <= rem_nx;
      val      <= val_nx;
      fillBusy <= (state_nx == FILL);
      fillDone <= (state_nx == DONE);
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    rem_nx   = rem;
    val_nx   = val;
    unique case (state)
      IDLE: begin
        if (fillStart) begin
          ptr_nx = fillBase;
          rem_nx = fillCount;
          val_nx = fillValue;
          if (fillCount == '0) begin
            state_nx = DONE;
          end else begin
            state_nx = FILL;
          end
        end
      end
      FILL: begin
        ptr_nx = ptr + 1'b1;
        rem_nx = rem - 1'b1;
        if (rem == {{AddrBits{1'b0}}, 1'b1}) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // The fill engine owns the write port while busy;
  // CPU writes in that window are dropped.
  assign fill_we = (state == FILL);
  assign wr_en   = fill_we | (aWriteEnabled & ~fillBusy);
  assign wr_addr = fill_we ? ptr : aAddress;
  assign wr_data = fill_we ? val : aDataIn;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Non-blocking read gives old data on a same-edge write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bDataOut <= '0;
    end else begin
      bDataOut <= mem[bAddress];
    end
  end

  assign aDataOut = mem[aAddress];
  assign aReady   = ~fillBusy;

endmodule

// File: tb/tb_dual_port_ram_fill.sv
// Scoreboard bench for dual_port_ram_fill: stimulus queues
// expected values, monitors pop and compare.
module tb_dual_port_ram_fill;

  logic        clk = 1'b0;
  logic        reset;
  logic        aWriteEnabled;
  logic [15:0] aAddress;
  logic [7:0]  aDataIn;
  logic [7:0]  aDataOut;
  logic        aReady;
  logic [15:0] bAddress;
  logic [7:0]  bDataOut;
  logic        fillStart;
  logic [15:0] fillBase;
  logic [16:0] fillCount;
  logic [7:0]  fillValue;
  logic        fillBusy;
  logic        fillDone;

  dual_port_ram_fill #(
    .AddrBits(16),
    .DataBits(8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .aWriteEnabled(aWriteEnabled),
    .aAddress     (aAddress),
    .aDataIn      (aDataIn),
    .aDataOut     (aDataOut),
    .aReady       (aReady),
    .bAddress     (bAddress),
    .bDataOut     (bDataOut),
    .fillStart    (fillStart),
    .fillBase     (fillBase),
    .fillCount    (fillCount),
    .fillValue    (fillValue),
    .fillBusy     (fillBusy),
    .fillDone     (fillDone)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          code;
    logic [15:0] val;
  } ent_t;

  ent_t qs[$];
  ent_t qa[$];
  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;
  event snap_ev;

  function automatic logic [15:0] act(int code);
    case (code)
      0:       return {8'h00, aDataOut};
      1:       return {8'h00, bDataOut};
      2:       return {15'h0, fillBusy};
      3:       return {15'h0, fillDone};
      default: return {15'h0, aReady};
    endcase
  endfunction

  function automatic string nm(int code);
    case (code)
      0:       return "aDataOut";
      1:       return "bDataOut";
      2:       return "fillBusy";
      3:       return "fillDone";
      default: return "aReady";
    endcase
  endfunction

  task automatic check(input ent_t e);
    logic [15:0] a;
    a = act(e.code);
    nvec++;
    if (a !== e.val) begin
      nerr++;
      $display("FAIL %s cyc %0d: got %h want %h",
               nm(e.code), cyc, a, e.val);
    end
  endtask

  // Clocked monitor: entries due at this edge.
  initial begin
    ent_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (qs.size() > 0 && qs[0].cyc <= cyc) begin
        e = qs.pop_front();
        check(e);
      end
    end
  end

  // Snapshot monitor: asynchronous checks.
  initial begin
    ent_t e;
    forever begin
      @(snap_ev);
      while (qa.size() > 0) begin
        e = qa.pop_front();
        check(e);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic ex(input int code, input logic [15:0] v,
                    input int d);
    ent_t e;
    e.cyc  = cyc + d;
    e.code = code;
    e.val  = v;
    qs.push_back(e);
  endtask

  task automatic exa(input int code, input logic [15:0] v);
    ent_t e;
    e.cyc  = -1;
    e.code = code;
    e.val  = v;
    qa.push_back(e);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    aWriteEnabled = 1'b1;
    aAddress      = a;
    aDataIn       = d;
    tick();
    aWriteEnabled = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] v);
    aAddress = a;
    bAddress = a;
    ex(0, {8'h00, v}, 1);
    ex(1, {8'h00, v}, 1);
    tick();
  endtask

  task automatic fill(input logic [15:0] b, input logic [16:0] n,
                      input logic [7:0] v);
    fillStart = 1'b1;
    fillBase  = b;
    fillCount = n;
    fillValue = v;
    tick();
    fillStart = 1'b0;
    fillBase  = 16'h0;
    fillCount = 17'h0;
    fillValue = 8'h0;
  endtask

  initial begin
    reset         = 1'b0;
    aWriteEnabled = 1'b0;
    aAddress      = 16'h0;
    aDataIn       = 8'h0;
    bAddress      = 16'h0;
    fillStart     = 1'b0;
    fillBase      = 16'h0;
    fillCount     = 17'h0;
    fillValue     = 8'h0;

    // Reset state.
    tick();
    ex(2, 16'h0, 1);
    ex(3, 16'h0, 1);
    ex(4, 16'h1, 1);
    ex(1, 16'h0, 1);
    tick();
    reset = 1'b1;
    tick();

    // 1: port A write, A and B reads.
    wr(16'h2000, 8'h77);
    rd(16'h2000, 8'h77);

    // 2: basic fill.
    for (int i = 16'h0F; i <= 16'h14; i++) begin
      wr(i[15:0], 8'h11);
    end
    ex(2, 16'h1, 1);
    ex(4, 16'h0, 1);
    ex(3, 16'h0, 1);
    ex(2, 16'h1, 2);
    ex(2, 16'h1, 3);
    ex(2, 16'h1, 4);
    ex(3, 16'h0, 4);
    ex(2, 16'h0, 5);
    ex(3, 16'h1, 5);
    ex(4, 16'h1, 5);
    ex(3, 16'h0, 6);
    fill(16'h0010, 17'd4, 8'hAA);
    repeat (5) tick();
    rd(16'h000F, 8'h11);
    rd(16'h0010, 8'hAA);
    rd(16'h0011, 8'hAA);
    rd(16'h0012, 8'hAA);
    rd(16'h0013, 8'hAA);
    rd(16'h0014, 8'h11);

    // 3: wrap across the top of memory.
    wr(16'hFFFD, 8'h33);
    wr(16'h0002, 8'h33);
    ex(2, 16'h1, 1);
    ex(2, 16'h1, 4);
    ex(3, 16'h1, 5);
    fill(16'hFFFE, 17'd4, 8'h55);
    repeat (5) tick();
    rd(16'hFFFD, 8'h33);
    rd(16'hFFFE, 8'h55);
    rd(16'hFFFF, 8'h55);
    rd(16'h0000, 8'h55);
    rd(16'h0001, 8'h55);
    rd(16'h0002, 8'h33);

    // 4: zero-length fill.
    wr(16'h0030, 8'h44);
    ex(2, 16'h0, 1);
    ex(3, 16'h1, 1);
    ex(4, 16'h1, 1);
    ex(2, 16'h0, 2);
    ex(3, 16'h0, 2);
    fill(16'h0030, 17'd0, 8'hEE);
    repeat (2) tick();
    rd(16'h0030, 8'h44);

    // 5: CPU write dropped during fill.
    wr(16'h0100, 8'h12);
    ex(2, 16'h1, 1);
    fill(16'h0200, 17'd3, 8'h5A);
    aWriteEnabled = 1'b1;
    aAddress      = 16'h0100;
    aDataIn       = 8'h99;
    ex(4, 16'h0, 1);
    ex(0, 16'h12, 1);
    tick();
    aWriteEnabled = 1'b0;
    repeat (4) tick();
    rd(16'h0100, 8'h12);
    wr(16'h0100, 8'h99);
    rd(16'h0100, 8'h99);
    rd(16'h0200, 8'h5A);
    rd(16'h0201, 8'h5A);
    rd(16'h0202, 8'h5A);

    // 6: async reset mid-fill, then a fresh fill.
    wr(16'h0082, 8'h21);
    wr(16'h0042, 8'h21);
    rd(16'h2000, 8'h77);
    ex(2, 16'h1, 1);
    ex(2, 16'h1, 3);
    fill(16'h0080, 17'd8, 8'h3C);
    repeat (2) tick();
    reset = 1'b0;
    #1;
    exa(2, 16'h0);
    exa(3, 16'h0);
    exa(1, 16'h0);
    exa(4, 16'h1);
    ->snap_ev;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    rd(16'h0080, 8'h3C);
    rd(16'h0081, 8'h3C);
    rd(16'h0082, 8'h21);
    ex(2, 16'h1, 1);
    ex(2, 16'h1, 2);
    ex(2, 16'h0, 3);
    ex(3, 16'h1, 3);
    ex(3, 16'h0, 4);
    fill(16'h0040, 17'd2, 8'hC3);
    repeat (3) tick();
    rd(16'h0040, 8'hC3);
    rd(16'h0041, 8'hC3);
    rd(16'h0042, 8'h21);

    repeat (3) tick();
    if (qs.size() != 0 || qa.size() != 0) begin
      nerr++;
      $display("FAIL drain: got %0d pending want 0",
               qs.size() + qa.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
